// File: rtl/mor1kx_rf_access_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mor1kx_rf_access_arbiter_pkg : shared constants and encodings for the RF
//                                access arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
package mor1kx_rf_access_arbiter_pkg;

  localparam logic [15:0] SPR_GPR_BASE  = 16'h0400;
  // GPRs live in SPR group 0 wherever addr[15:9] matches the base.
  localparam logic [6:0]  SPR_GPR_GROUP = SPR_GPR_BASE[15:9];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_SPR = 1'b0,
    OWN_SS  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mor1kx_rf_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mor1kx_rf_access_arbiter : shares the RF write port and auxiliary read port
//                            between writeback, SPR-bus GPR access and CSAW
// Revision : 1.0
// ---------------------------------------------------------------------------
module mor1kx_rf_access_arbiter
  import mor1kx_rf_access_arbiter_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
  input  logic                            padv_ctrl_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  input  logic                            ss_req_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ss_adr_i,
  output logic                            ss_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ss_dat_o,
  output logic                            rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_re_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_rdadr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_rddat_i
);

  state_t                          r_state, w_state_nxt;
  owner_t                          r_owner, w_owner_nxt;
  owner_t                          r_last_grant, w_last_grant_nxt;
  owner_t                          w_grant;
  logic                            r_fwd_vld, w_fwd_vld_nxt;
  logic [OPTION_OPERAND_WIDTH-1:0] r_fwd_dat, w_fwd_dat_nxt;
  logic [OPTION_OPERAND_WIDTH-1:0] r_ss_dat, w_ss_dat_nxt;

  logic                            w_gpr_hit;
  logic [OPTION_RF_ADDR_WIDTH-1:0] w_spr_adr;
  logic                            w_spr_wr;
  logic                            w_spr_rd;
  logic                            w_we;
  logic [OPTION_RF_ADDR_WIDTH-1:0] w_wradr;
  logic [OPTION_OPERAND_WIDTH-1:0] w_wrdat;
  logic [OPTION_OPERAND_WIDTH-1:0] w_rd_dat;

  assign w_gpr_hit = (spr_bus_addr_i[15:9] == SPR_GPR_GROUP);
  assign w_spr_adr = spr_bus_addr_i[OPTION_RF_ADDR_WIDTH-1:0];
  assign w_spr_wr  = spr_bus_stb_i & spr_bus_we_i & w_gpr_hit;
  assign w_spr_rd  = spr_bus_stb_i & ~spr_bus_we_i & w_gpr_hit & ~padv_ctrl_i;

  // Writeback always owns the write port; a colliding SPR write retries.
  assign w_we    = wb_rf_wb_i | w_spr_wr;
  assign w_wradr = wb_rf_wb_i ? wb_rfd_adr_i : w_spr_adr;
  assign w_wrdat = wb_rf_wb_i ? result_i : spr_bus_dat_i;

  // The RAM has no bypass, so a write landing on the read address during
  // the issue cycle is substituted here.
  assign w_rd_dat = r_fwd_vld ? r_fwd_dat : rf_rddat_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_fwd_vld_nxt    = 1'b0;
    w_fwd_dat_nxt    = r_fwd_dat;
    w_ss_dat_nxt     = r_ss_dat;
    w_grant          = OWN_SPR;

    rf_we_o       = w_we;
    rf_wradr_o    = w_we ? w_wradr : '0;
    rf_wrdat_o    = w_we ? w_wrdat : '0;
    rf_re_o       = 1'b0;
    rf_rdadr_o    = '0;
    spr_gpr_ack_o = w_spr_wr & ~wb_rf_wb_i;
    spr_gpr_dat_o = '0;
    ss_ack_o      = 1'b0;
    ss_dat_o      = r_ss_dat;

    case (r_state)
      ST_IDLE: begin
        if (w_spr_rd | ss_req_i) begin
          if (w_spr_rd && ss_req_i)
            w_grant = (r_last_grant == OWN_SS) ? OWN_SPR : OWN_SS;
          else
            w_grant = w_spr_rd ? OWN_SPR : OWN_SS;
          rf_re_o       = 1'b1;
          rf_rdadr_o    = (w_grant == OWN_SPR) ? w_spr_adr : ss_adr_i;
          w_owner_nxt   = w_grant;
          w_fwd_vld_nxt = w_we && (w_wradr == rf_rdadr_o);
          w_fwd_dat_nxt = w_wrdat;
          w_state_nxt   = ST_RD;
        end
      end
      ST_RD: begin
        if (r_owner == OWN_SS) begin
          ss_ack_o     = 1'b1;
          ss_dat_o     = w_rd_dat;
          w_ss_dat_nxt = w_rd_dat;
        end else if (spr_bus_stb_i && !spr_bus_we_i && w_gpr_hit) begin
          spr_gpr_ack_o = 1'b1;
          spr_gpr_dat_o = w_rd_dat;
        end
        w_last_grant_nxt = r_owner;
        w_state_nxt      = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (rst) begin
      rf_we_o       = 1'b0;
      rf_wradr_o    = '0;
      rf_wrdat_o    = '0;
      rf_re_o       = 1'b0;
      rf_rdadr_o    = '0;
      spr_gpr_ack_o = 1'b0;
      spr_gpr_dat_o = '0;
      ss_ack_o      = 1'b0;
      ss_dat_o      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_SPR;
      r_last_grant <= OWN_SS;
      r_fwd_vld    <= 1'b0;
      r_fwd_dat    <= '0;
      r_ss_dat     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_fwd_vld    <= w_fwd_vld_nxt;
      r_fwd_dat    <= w_fwd_dat_nxt;
      r_ss_dat     <= w_ss_dat_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_rf_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mor1kx_rf_access_arbiter : scoreboard bench for the RF access arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mor1kx_rf_access_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_rf_wb_i;
  logic [4:0]  wb_rfd_adr_i;
  logic [31:0] result_i;
  logic        padv_ctrl_i;
  logic [15:0] spr_bus_addr_i;
  logic        spr_bus_stb_i;
  logic        spr_bus_we_i;
  logic [31:0] spr_bus_dat_i;
  logic        spr_gpr_ack_o;
  logic [31:0] spr_gpr_dat_o;
  logic        ss_req_i;
  logic [4:0]  ss_adr_i;
  logic        ss_ack_o;
  logic [31:0] ss_dat_o;
  logic        rf_we_o;
  logic [4:0]  rf_wradr_o;
  logic [31:0] rf_wrdat_o;
  logic        rf_re_o;
  logic [4:0]  rf_rdadr_o;
  logic [31:0] rf_rddat_i;

  mor1kx_rf_access_arbiter #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_rf_wb_i(wb_rf_wb_i), .wb_rfd_adr_i(wb_rfd_adr_i), .result_i(result_i),
    .padv_ctrl_i(padv_ctrl_i),
    .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i),
    .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o), .spr_gpr_dat_o(spr_gpr_dat_o),
    .ss_req_i(ss_req_i), .ss_adr_i(ss_adr_i),
    .ss_ack_o(ss_ack_o), .ss_dat_o(ss_dat_o),
    .rf_we_o(rf_we_o), .rf_wradr_o(rf_wradr_o), .rf_wrdat_o(rf_wrdat_o),
    .rf_re_o(rf_re_o), .rf_rdadr_o(rf_rdadr_o), .rf_rddat_i(rf_rddat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, no write-to-read bypass.
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (rf_re_o) rf_rddat_i <= ram[rf_rdadr_o];
    if (rf_we_o) ram[rf_wradr_o] <= rf_wrdat_o;
  end

  typedef struct {
    logic        is_wr;
    logic [4:0]  adr;
    logic [31:0] dat;
  } spr_exp_t;

  spr_exp_t    spr_q[$];
  logic [31:0] ss_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (ss_ack_o) begin
        if (ss_q.size() == 0) check("ss_unexpected_ack", 32'd1, 32'd0);
        else check("ss_dat", ss_dat_o, ss_q.pop_front());
      end
      if (spr_gpr_ack_o) begin
        if (spr_q.size() == 0) check("spr_unexpected_ack", 32'd1, 32'd0);
        else begin
          spr_exp_t e;
          e = spr_q.pop_front();
          if (e.is_wr) begin
            check("spr_wr_we", {31'd0, rf_we_o}, 32'd1);
            check("spr_wr_adr", {27'd0, rf_wradr_o}, {27'd0, e.adr});
            check("spr_wr_dat", rf_wrdat_o, e.dat);
          end else begin
            check("spr_rd_dat", spr_gpr_dat_o, e.dat);
          end
        end
      end
    end
  end

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat);
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = adr; result_i = dat;
    @(negedge clk);
    check("wb_we", {31'd0, rf_we_o}, 32'd1);
    check("wb_adr", {27'd0, rf_wradr_o}, {27'd0, adr});
    check("wb_dat", rf_wrdat_o, dat);
    tick();
    wb_rf_wb_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, {31'd0, rf_we_o}, 32'd0);
    check({tag, "_re"}, {31'd0, rf_re_o}, 32'd0);
    check({tag, "_spr_ack"}, {31'd0, spr_gpr_ack_o}, 32'd0);
    check({tag, "_ss_ack"}, {31'd0, ss_ack_o}, 32'd0);
    check({tag, "_ss_dat"}, ss_dat_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wb_rf_wb_i = 1'b0; wb_rfd_adr_i = '0; result_i = '0;
    padv_ctrl_i = 1'b0; spr_bus_addr_i = '0; spr_bus_stb_i = 1'b0;
    spr_bus_we_i = 1'b0; spr_bus_dat_i = '0; ss_req_i = 1'b0; ss_adr_i = '0;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rst = 1'b0;

    wb_write(5'd3, 32'h0000_0333);
    wb_write(5'd4, 32'h0000_0444);
    wb_write(5'd5, 32'h5555_0005);
    wb_write(5'd9, 32'h0000_1000);

    // Writeback to r9 in the grant cycle is forwarded to the SS read.
    ss_req_i = 1'b1; ss_adr_i = 5'd9;
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd9; result_i = 32'h0000_DEAD;
    ss_q.push_back(32'h0000_DEAD);
    @(negedge clk);
    check("t1_re", {31'd0, rf_re_o}, 32'd1);
    check("t1_rdadr", {27'd0, rf_rdadr_o}, 32'd9);
    check("t1_we", {31'd0, rf_we_o}, 32'd1);
    check("t1_wradr", {27'd0, rf_wradr_o}, 32'd9);
    tick();
    wb_rf_wb_i = 1'b0;
    @(negedge clk);
    check("t1_ack", {31'd0, ss_ack_o}, 32'd1);
    tick();
    ss_req_i = 1'b0;
    @(negedge clk);
    check("t1_hold_dat", ss_dat_o, 32'h0000_DEAD);
    check("t1_no_ack", {31'd0, ss_ack_o}, 32'd0);
    tick();

    // A write during RD is not forwarded.
    ss_req_i = 1'b1; ss_adr_i = 5'd9;
    ss_q.push_back(32'h0000_DEAD);
    @(negedge clk);
    check("t1b_re", {31'd0, rf_re_o}, 32'd1);
    tick();
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd9; result_i = 32'h0000_BEEF;
    @(negedge clk);
    check("t1b_ack", {31'd0, ss_ack_o}, 32'd1);
    tick();
    wb_rf_wb_i = 1'b0; ss_req_i = 1'b0;

    // SPR write collides with writeback, then retries.
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
    spr_bus_addr_i = 16'h0403; spr_bus_dat_i = 32'h55;
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd4; result_i = 32'h77;
    @(negedge clk);
    check("t2_wradr", {27'd0, rf_wradr_o}, 32'd4);
    check("t2_wrdat", rf_wrdat_o, 32'h77);
    check("t2_no_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    tick();
    wb_rf_wb_i = 1'b0;
    spr_q.push_back('{1'b1, 5'd3, 32'h55});
    @(negedge clk);
    check("t2_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;

    // SPR write completes while an SS read is in RD.
    ss_req_i = 1'b1; ss_adr_i = 5'd3;
    ss_q.push_back(32'h55);
    @(negedge clk);
    tick();
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
    spr_bus_addr_i = 16'h0404; spr_bus_dat_i = 32'h99;
    spr_q.push_back('{1'b1, 5'd4, 32'h99});
    @(negedge clk);
    check("cc_ss_ack", {31'd0, ss_ack_o}, 32'd1);
    check("cc_spr_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    ss_req_i = 1'b0; spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;

    // Round-robin from reset: SPR first, then alternating.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b0; spr_bus_addr_i = 16'h0405;
    ss_req_i = 1'b1; ss_adr_i = 5'd9;
    for (int i = 0; i < 10; i++) begin
      spr_q.push_back('{1'b0, 5'd5, 32'h5555_0005});
      @(negedge clk);
      check("t3_spr_grant", {27'd0, rf_rdadr_o}, 32'd5);
      tick();
      @(negedge clk);
      check("t3_spr_ack", {30'd0, spr_gpr_ack_o, ss_ack_o}, 32'd2);
      tick();
      ss_q.push_back(32'h0000_BEEF);
      @(negedge clk);
      check("t3_ss_grant", {27'd0, rf_rdadr_o}, 32'd9);
      tick();
      @(negedge clk);
      check("t3_ss_ack", {30'd0, spr_gpr_ack_o, ss_ack_o}, 32'd1);
      tick();
    end
    spr_bus_stb_i = 1'b0; ss_req_i = 1'b0;

    // padv_ctrl_i blocks the SPR read until it falls.
    padv_ctrl_i = 1'b1;
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b0; spr_bus_addr_i = 16'h0405;
    repeat (3) begin
      @(negedge clk);
      check("t4_blocked", {31'd0, rf_re_o}, 32'd0);
      tick();
    end
    padv_ctrl_i = 1'b0;
    spr_q.push_back('{1'b0, 5'd5, 32'h5555_0005});
    @(negedge clk);
    check("t4_grant", {31'd0, rf_re_o}, 32'd1);
    tick();
    @(negedge clk);
    check("t4_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_bus_stb_i = 1'b0;

    // SPR read abandoned during RD: no ack.
    spr_bus_stb_i = 1'b1; spr_bus_addr_i = 16'h0403;
    @(negedge clk);
    check("ab_rdadr", {27'd0, rf_rdadr_o}, 32'd3);
    tick();
    spr_bus_stb_i = 1'b0;
    @(negedge clk);
    check("ab_no_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    tick();

    // Reset while in RD.
    ss_req_i = 1'b1; ss_adr_i = 5'd9;
    @(negedge clk);
    check("t5_re", {31'd0, rf_re_o}, 32'd1);
    tick();
    rst = 1'b1; ss_req_i = 1'b0;
    @(negedge clk);
    check("t5_no_ack", {31'd0, ss_ack_o}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t5_after");
    tick();
    ss_req_i = 1'b1; ss_adr_i = 5'd4;
    ss_q.push_back(32'h99);
    @(negedge clk);
    check("t5_regrant", {31'd0, rf_re_o}, 32'd1);
    tick();
    @(negedge clk);
    check("t5_ack", {31'd0, ss_ack_o}, 32'd1);
    tick();
    ss_req_i = 1'b0;

    // Non-GPR SPR address is ignored.
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
    spr_bus_addr_i = 16'h0011; spr_bus_dat_i = 32'h1234;
    repeat (2) begin
      @(negedge clk);
      check("t6_wr_we", {31'd0, rf_we_o}, 32'd0);
      check("t6_wr_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
      tick();
    end
    spr_bus_we_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t6_rd_re", {31'd0, rf_re_o}, 32'd0);
      check("t6_rd_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
      tick();
    end
    spr_bus_stb_i = 1'b0;

    repeat (2) tick();
    check("spr_q_drained", spr_q.size(), 32'd0);
    check("ss_q_drained", ss_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
